// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : mod_updown_counter
// Brief    : Modulo up/down counter with enable prescaler, parallel load,
//            wrap/saturate mode, registered terminal-count and sticky overflow.
// Revision : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int PRESCALE  = 1,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             at_max,
  output logic             at_zero
);

  // MODULUS-1 keeps the compare inside WIDTH bits even when MODULUS == 2**WIDTH.
  localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_VAL);

  logic             w_tick;
  logic             w_boundary;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_load_clamped;

  generate
    if (PRESCALE > 1) begin : g_psc
      localparam int PSC_W = $clog2(PRESCALE);
      localparam logic [PSC_W-1:0] c_psc_last = PSC_W'(PRESCALE - 1);
      logic [PSC_W-1:0] r_psc;

      assign w_tick = en && (r_psc == c_psc_last);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_psc <= '0;
        end else if (load || w_tick) begin
          r_psc <= '0;
        end else if (en) begin
          r_psc <= r_psc + 1'b1;
        end
      end
    end else begin : g_no_psc
      assign w_tick = en;
    end
  endgenerate

  assign at_max  = (count == c_max);
  assign at_zero = (count == '0);

  assign w_load_clamped = (load_val > c_max) ? c_max : load_val;

  always_comb begin
    w_boundary = 1'b0;
    w_next     = count;
    if (up_dn) begin
      if (at_max) begin
        w_boundary = 1'b1;
        w_next     = sat_mode ? c_max : '0;
      end else begin
        w_next = count + 1'b1;
      end
    end else begin
      if (at_zero) begin
        w_boundary = 1'b1;
        w_next     = sat_mode ? '0 : c_max;
      end else begin
        w_next = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= c_reset;
      tc    <= 1'b0;
    end else if (load) begin
      count <= w_load_clamped;
      tc    <= 1'b0;
    end else if (w_tick) begin
      count <= w_next;
      tc    <= w_boundary;
    end else begin
      tc    <= 1'b0;
    end
  end

  // A boundary event outranks a simultaneous clear; load suppresses the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (!load && w_tick && w_boundary) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// Testbench for mod_updown_counter: two configurations driven in lockstep,
// expected values queued by a behavioural model and checked by a monitor.
module tb_mod_updown_counter;

  logic       clk;
  logic       rst, en, up_dn, sat_mode, load, clr_ovf;
  logic [3:0] load_val;
  logic [3:0] count_a, count_b;
  logic       tc_a, ovf_a, at_max_a, at_zero_a;
  logic       tc_b, ovf_b, at_max_b, at_zero_b;

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1), .RESET_VAL(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count_a), .tc(tc_a), .ovf(ovf_a), .at_max(at_max_a), .at_zero(at_zero_a)
  );

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .RESET_VAL(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
    .count(count_b), .tc(tc_b), .ovf(ovf_b), .at_max(at_max_b), .at_zero(at_zero_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
    bit amax;
    bit azero;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, one entry per instance (0 = dut_a, 1 = dut_b).
  int mod_v[2] = '{16, 10};
  int psc_v[2] = '{1, 3};
  int rst_v[2] = '{0, 3};
  int m_cnt[2];
  int m_psc[2];
  bit m_tc[2];
  bit m_ovf[2];

  function automatic void model_step(int k, bit r, bit e, bit u, bit s, bit l, int lv, bit c);
    int  lim;
    bit  tick;
    bit  ev;
    lim  = mod_v[k] - 1;
    tick = 1'b0;
    ev   = 1'b0;
    if (r) begin
      m_cnt[k] = rst_v[k]; m_psc[k] = 0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
      return;
    end
    if (l) begin
      m_cnt[k] = (lv > lim) ? lim : lv;
      m_psc[k] = 0;
      m_tc[k]  = 1'b0;
      if (c) m_ovf[k] = 1'b0;
      return;
    end
    if (e) begin
      m_psc[k] = m_psc[k] + 1;
      if (m_psc[k] == psc_v[k]) begin
        tick = 1'b1;
        m_psc[k] = 0;
      end
    end
    if (tick) begin
      if (u) begin
        if (m_cnt[k] == lim) begin ev = 1'b1; m_cnt[k] = s ? lim : 0; end
        else m_cnt[k] = m_cnt[k] + 1;
      end else begin
        if (m_cnt[k] == 0) begin ev = 1'b1; m_cnt[k] = s ? 0 : lim; end
        else m_cnt[k] = m_cnt[k] - 1;
      end
    end
    m_tc[k] = ev;
    if (ev) m_ovf[k] = 1'b1;
    else if (c) m_ovf[k] = 1'b0;
  endfunction

  function automatic exp_t model_exp(int k);
    exp_t x;
    x.cnt   = m_cnt[k];
    x.tc    = m_tc[k];
    x.ovf   = m_ovf[k];
    x.amax  = (m_cnt[k] == mod_v[k] - 1);
    x.azero = (m_cnt[k] == 0);
    return x;
  endfunction

  function automatic void check(string name, exp_t x, int cnt, bit t, bit o, bit amx, bit azr);
    n_checks++;
    if (cnt != x.cnt || t != x.tc || o != x.ovf || amx != x.amax || azr != x.azero) begin
      n_fail++;
      $display("FAIL %s @%0t: got cnt=%0d tc=%0b ovf=%0b at_max=%0b at_zero=%0b, expected cnt=%0d tc=%0b ovf=%0b at_max=%0b at_zero=%0b",
               name, $time, cnt, t, o, amx, azr, x.cnt, x.tc, x.ovf, x.amax, x.azero);
    end
  endfunction

  task automatic push_expected();
    q_a.push_back(model_exp(0));
    q_b.push_back(model_exp(1));
  endtask

  task automatic drive(bit r, bit e, bit u, bit s, bit l, int lv, bit c);
    @(negedge clk);
    rst = r; en = e; up_dn = u; sat_mode = s; load = l; load_val = 4'(lv); clr_ovf = c;
    for (int k = 0; k < 2; k++) model_step(k, r, e, u, s, l, lv, c);
    push_expected();
  endtask

  // Reset asserted between edges; its effect must be visible before the next clk edge.
  task automatic async_reset_mid_cycle();
    @(negedge clk);
    en = 1'b1; load = 1'b0; clr_ovf = 1'b0;
    #2 rst = 1'b1;
    for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b1, up_dn, sat_mode, 1'b0, 0, 1'b0);
    #1;
    check("async_rst_a", model_exp(0), count_a, tc_a, ovf_a, at_max_a, at_zero_a);
    check("async_rst_b", model_exp(1), count_b, tc_b, ovf_b, at_max_b, at_zero_b);
    push_expected();
  endtask

  // Monitor: every clock presents a new output; pop and compare after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        x = q_a.pop_front();
        check("cycle_a", x, count_a, tc_a, ovf_a, at_max_a, at_zero_a);
      end
      if (q_b.size() > 0) begin
        x = q_b.pop_front();
        check("cycle_b", x, count_b, tc_b, ovf_b, at_max_b, at_zero_b);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
    load_val = 4'd0; clr_ovf = 1'b0;
    for (int k = 0; k < 2; k++) model_step(k, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Reset then up-count with wrap.
    drive(1, 1, 1, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0, 0);
    repeat (20) drive(0, 1, 1, 0, 0, 0, 0);

    // Down-count with wrap.
    repeat (36) drive(0, 1, 0, 0, 0, 0, 0);

    // Saturate up from a loaded 7, then overflow clear interplay.
    drive(0, 0, 1, 1, 1, 7, 0);
    repeat (12) drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 1, 0, 0, 1);
    drive(0, 1, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 1);
    drive(0, 0, 1, 1, 0, 0, 0);

    // Load clamp beats a simultaneous tick.
    drive(0, 1, 1, 0, 1, 15, 0);
    drive(0, 1, 1, 0, 0, 0, 0);

    // Prescale gating pattern 1,1,0,1 with a load in the middle of a window.
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0);
      if (i == 2) drive(0, 1, 1, 0, 1, 2, 0);
    end

    // Asynchronous reset at count 5, then resume.
    drive(0, 0, 1, 0, 1, 5, 0);
    async_reset_mid_cycle();
    repeat (8) drive(0, 1, 1, 0, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) < 4),
            (i >= 300),
            ($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++;
      $display("FAIL drain: queue sizes a=%0d b=%0d, expected 0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
